// File: rtl/cordic_seq_ctrl.sv
// Sequencer for baby_cordic: float angle -> converter screen -> datapath load -> ITERATIONS step strobes.
// Latency ITERATIONS+2 cycles start-to-done; starts arriving while busy are dropped and flagged via overrun.
module cordic_seq_ctrl #(
  parameter int ITERATIONS = 16,
  parameter int IDX_W      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      angle_fp,
  input  logic             result_ack,
  output logic [31:0]      conv_fp_in,
  input  logic [18:0]      conv_fixed,
  input  logic             conv_invalid,
  output logic             dp_load,
  output logic [18:0]      dp_angle,
  output logic             dp_step,
  output logic [IDX_W-1:0] dp_iter,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             overrun
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONVERT = 2'd1,
    S_ITER    = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ITERATIONS - 1);

  state_t           state_q;
  logic [IDX_W-1:0] counter_q;
  logic [18:0]      angle_q;
  logic [31:0]      fp_q;
  logic             done_q;
  logic             err_q;
  logic             overrun_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      counter_q <= '0;
      angle_q   <= '0;
      fp_q      <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            fp_q      <= angle_fp;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            overrun_q <= 1'b0;
            state_q   <= S_CONVERT;
          end
        end
        S_CONVERT: begin
          if (start) overrun_q <= 1'b1;
          if (conv_invalid) begin
            done_q  <= 1'b1;
            err_q   <= 1'b1;
            state_q <= S_DONE;
          end else begin
            angle_q   <= conv_fixed;
            counter_q <= '0;
            state_q   <= S_ITER;
          end
        end
        S_ITER: begin
          if (start) overrun_q <= 1'b1;
          if (counter_q == LAST_IDX) begin
            done_q  <= 1'b1;
            err_q   <= 1'b0;
            state_q <= S_DONE;
          end else begin
            counter_q <= counter_q + 1'b1;
          end
        end
        S_DONE: begin
          // A new start takes priority over acknowledging the old result.
          if (start) begin
            fp_q      <= angle_fp;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            overrun_q <= 1'b0;
            state_q   <= S_CONVERT;
          end else if (result_ack) begin
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // The converter is combinational, so the load strobe and angle pass through in the CONVERT cycle.
  assign dp_load    = (state_q == S_CONVERT) && !conv_invalid;
  assign dp_angle   = dp_load ? conv_fixed : angle_q;
  assign dp_step    = (state_q == S_ITER);
  assign dp_iter    = counter_q;
  assign busy       = (state_q == S_CONVERT) || (state_q == S_ITER);
  assign conv_fp_in = fp_q;
  assign done       = done_q;
  assign err        = err_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_cordic_seq_ctrl.sv
// Directed bench for cordic_seq_ctrl with a small table-driven stand-in for the float-to-fixed converter.
module tb_cordic_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] angle_fp;
  logic        result_ack;
  logic [31:0] conv_fp_in;
  logic [18:0] conv_fixed;
  logic        conv_invalid;
  logic        dp_load;
  logic [18:0] dp_angle;
  logic        dp_step;
  logic [3:0]  dp_iter;
  logic        busy;
  logic        done;
  logic        err;
  logic        overrun;

  int checks = 0;
  int errors = 0;

  cordic_seq_ctrl #(.ITERATIONS(16), .IDX_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .angle_fp(angle_fp),
    .result_ack(result_ack), .conv_fp_in(conv_fp_in), .conv_fixed(conv_fixed),
    .conv_invalid(conv_invalid), .dp_load(dp_load), .dp_angle(dp_angle),
    .dp_step(dp_step), .dp_iter(dp_iter), .busy(busy), .done(done),
    .err(err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Converter stand-in: known angles map to hand-computed 3.16 values.
  always_comb begin
    conv_fixed   = 19'h0;
    conv_invalid = 1'b0;
    case (conv_fp_in)
      32'h3F800000: conv_fixed = 19'h10000;   // 1.0
      32'hBF000000: conv_fixed = 19'h78000;   // -0.5
      32'h40000000: conv_fixed = 19'h20000;   // 2.0
      32'h40500000: conv_invalid = 1'b1;      // 3.25 > pi
      32'h7FC00000: conv_invalid = 1'b1;      // NaN
      default: conv_fixed = 19'h0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [31:0] a);
    angle_fp = a;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  // Runs one valid op from cycle 1 to cycle 18; optionally pulses start at cycle 5 or ack mid-ITER.
  task automatic run_valid(input logic [31:0] a, input logic [18:0] fx,
                           input bit pulse_start, input bit pulse_ack);
    launch(a);
    check("c1_load", {31'b0, dp_load}, 32'd1);
    check("c1_angle", {13'b0, dp_angle}, {13'b0, fx});
    check("c1_busy", {31'b0, busy}, 32'd1);
    check("c1_step", {31'b0, dp_step}, 32'd0);
    check("c1_done", {31'b0, done}, 32'd0);
    for (int i = 0; i < 16; i++) begin
      tick();
      result_ack = 1'b0;
      start      = 1'b0;
      check("it_step", {31'b0, dp_step}, 32'd1);
      check("it_iter", {28'b0, dp_iter}, i);
      check("it_load", {31'b0, dp_load}, 32'd0);
      check("it_hold", {13'b0, dp_angle}, {13'b0, fx});
      check("it_done", {31'b0, done}, 32'd0);
      if (pulse_start && i == 3) begin
        angle_fp = 32'h40000000;
        start    = 1'b1;            // sampled at edge 5
      end
      if (pulse_ack && i == 5) result_ack = 1'b1;
    end
    tick();
    start      = 1'b0;
    result_ack = 1'b0;
    check("c18_done", {31'b0, done}, 32'd1);
    check("c18_err", {31'b0, err}, 32'd0);
    check("c18_busy", {31'b0, busy}, 32'd0);
    check("c18_step", {31'b0, dp_step}, 32'd0);
    check("c18_fp", conv_fp_in, a);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_fp"}, conv_fp_in, 32'h0);
    check({tag, "_iter"}, {28'b0, dp_iter}, 32'h0);
    check({tag, "_angle"}, {13'b0, dp_angle}, 32'h0);
    check({tag, "_flags"}, {25'b0, dp_load, dp_step, busy, done, err, overrun},
          32'h0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; angle_fp = 32'h0; result_ack = 1'b0;
    tick(); tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // 1: nominal 1.0 rad
    run_valid(32'h3F800000, 19'h10000, 1'b0, 1'b0);
    check("t1_ovr", {31'b0, overrun}, 32'd0);
    result_ack = 1'b1; tick(); result_ack = 1'b0;

    // 2: 3.25 rejected by converter
    launch(32'h40500000);
    check("t2_c1_busy", {31'b0, busy}, 32'd1);
    check("t2_c1_load", {31'b0, dp_load}, 32'd0);
    check("t2_c1_done", {31'b0, done}, 32'd0);
    tick();
    check("t2_c2_done", {31'b0, done}, 32'd1);
    check("t2_c2_err", {31'b0, err}, 32'd1);
    check("t2_c2_busy", {31'b0, busy}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      check("t2_nostep", {30'b0, dp_step, dp_load}, 32'd0);
      tick();
    end
    check("t2_sticky", {30'b0, done, err}, 32'd3);

    // 4 (from DONE after error): start and ack together; start wins
    angle_fp = 32'hBF000000; start = 1'b1; result_ack = 1'b1;
    tick();
    start = 1'b0; result_ack = 1'b0;
    check("t4_busy", {31'b0, busy}, 32'd1);
    check("t4_done", {31'b0, done}, 32'd0);
    check("t4_err", {31'b0, err}, 32'd0);
    check("t4_fp", conv_fp_in, 32'hBF000000);
    check("t4_angle", {13'b0, dp_angle}, 32'h78000);
    for (int i = 0; i < 17; i++) tick();
    check("t4_done18", {31'b0, done}, 32'd1);

    // 3: start during ITER is dropped and flagged
    run_valid(32'h3F800000, 19'h10000, 1'b1, 1'b0);
    check("t3_ovr", {31'b0, overrun}, 32'd1);
    run_valid(32'hBF000000, 19'h78000, 1'b0, 1'b0);
    check("t3_ovr_clr", {31'b0, overrun}, 32'd0);

    // 6: ack during ITER ignored; ack in DONE returns to IDLE
    run_valid(32'h40000000, 19'h20000, 1'b0, 1'b1);
    result_ack = 1'b1; tick(); result_ack = 1'b0;
    check("t6_ack", {29'b0, busy, done, err}, 32'd0);
    tick(); tick();
    check("t6_idle", {29'b0, busy, done, err}, 32'd0);

    // 5: reset mid-op at cycle 8
    launch(32'h3F800000);
    for (int i = 1; i < 8; i++) tick();
    check("t5_c8_step", {31'b0, dp_step}, 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_all_zero("t5_rst");
    tick();
    check("t5_stay", {31'b0, busy}, 32'd0);
    run_valid(32'h3F800000, 19'h10000, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
